// File: rtl/lisa_uart_rx_fifo.sv
// UART receiver (5..9 data bits, optional run-time parity, OVS oversampling) feeding a FWFT receive FIFO.
// Words land in the FIFO on the stop-bit sample edge; a frame that arrives while the FIFO is full raises sticky overrun.

module lisa_uart_rx_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       avail
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;
  logic          wr_ok;

  assign full   = (count == CNT_W'(DEPTH));
  assign avail  = (count != '0);
  assign pop_ok = pop && avail;
  // A full buffer still accepts a word when a pop frees the head slot in the same cycle.
  assign wr_ok  = push && (!full || pop_ok);
  assign head   = avail ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module lisa_uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int OVS    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    baud_ref,
  input  logic                    rxd,
  input  logic                    parity_en,
  input  logic                    parity_odd,
  input  logic                    rd,
  output logic [DATA_W-1:0]       d,
  output logic                    data_avail,
  output logic                    fifo_full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    overrun,
  input  logic                    err_clr
);
  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rx_meta;
  logic              rxs;
  logic [CW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_en_q;
  logic              par_odd_q;
  logic              par_ok;
  logic              tick_half;
  logic              tick_bit;
  logic              sample;
  logic              shift_en;
  logic              par_chk;
  logic              push;
  logic              perr_set;
  logic              ferr_set;
  logic              ovr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign tick_half = baud_ref && (tick_cnt == CW'(OVS/2 - 1));
  assign tick_bit  = baud_ref && (tick_cnt == CW'(OVS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    push      = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) state_nxt = S_START;
      end
      S_START: begin
        if (tick_half) begin
          sample    = 1'b1;
          state_nxt = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_bit) begin
          sample   = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == BW'(DATA_W - 1)) state_nxt = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick_bit) begin
          sample    = 1'b1;
          par_chk   = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_bit) begin
          sample = 1'b1;
          if (!rxs) begin
            // A low stop bit is a framing error; parity is not judged.
            ferr_set  = 1'b1;
            state_nxt = S_BREAK;
          end else begin
            state_nxt = S_IDLE;
            push      = par_ok;
            perr_set  = !par_ok;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_ok    <= 1'b1;
    end else begin
      if (state == S_IDLE) begin
        // Parity mode is captured here and held for the whole frame.
        tick_cnt  <= '0;
        bit_cnt   <= '0;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
        par_ok    <= 1'b1;
      end else if (baud_ref) begin
        tick_cnt <= sample ? '0 : tick_cnt + CW'(1);
      end
      if (shift_en) begin
        shreg   <= {rxs, shreg[DATA_W-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (par_chk) par_ok <= (((^shreg) ^ rxs) == par_odd_q);
    end
  end

  assign ovr_set = push && fifo_full && !rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (perr_set)     parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

  lisa_uart_rx_fifo_buf #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (rd),
    .head      (d),
    .count     (count),
    .full      (fifo_full),
    .avail     (data_avail)
  );
endmodule

// File: tb/tb_lisa_uart_rx_fifo.sv
// Directed bench for lisa_uart_rx_fifo: 8 data bits, 4-deep FIFO, OVS 16, baud_ref every 4 clocks.
module tb_lisa_uart_rx_fifo;
  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst;
  logic       baud_ref;
  logic       rxd;
  logic       parity_en;
  logic       parity_odd;
  logic       rd;
  logic       err_clr;
  logic [7:0] d;
  logic       data_avail;
  logic       fifo_full;
  logic [2:0] count;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int total  = 0;
  int passed = 0;
  int bcnt   = 0;

  lisa_uart_rx_fifo #(.DATA_W(8), .DEPTH(4), .OVS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_ref   (baud_ref),
    .rxd        (rxd),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rd         (rd),
    .d          (d),
    .data_avail (data_avail),
    .fifo_full  (fifo_full),
    .count      (count),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial baud_ref = 1'b0;
  always @(negedge clk) begin
    bcnt = bcnt + 1;
    baud_ref = ((bcnt % 4) == 0);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic       exp_push;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] data);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pen, input logic pbit, input logic stop);
    send_head(data);
    if (pen) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic got;
    logic bsamp;

    //             data   pen   podd  pbit  stop  push  perr  ferr
    vecs[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; rxd = 1'b1; parity_en = 1'b0; parity_odd = 1'b0; rd = 1'b0; err_clr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset count", 32'(count), 32'd0);
    check("reset data_avail", 32'(data_avail), 32'd0);
    check("reset fifo_full", 32'(fifo_full), 32'd0);
    check("reset d", 32'(d), 32'd0);
    check("reset flags", 32'({frame_err, parity_err, overrun}), 32'd0);

    // 0xA5 8N1: word must appear one cycle after a baud_ref edge during the stop bit.
    send_head(8'hA5);
    rxd = 1'b1;
    got = 1'b0;
    bsamp = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge clk);
      bsamp = baud_ref;
      @(negedge clk);
      got = data_avail;
    end
    check("a5 push seen", 32'(got), 32'd1);
    check("a5 push on baud edge", 32'(bsamp), 32'd1);
    check("a5 d", 32'(d), 32'hA5);
    check("a5 count", 32'(count), 32'd1);
    idle(BIT_CLKS);
    pulse_rd();
    check("a5 count after rd", 32'(count), 32'd0);
    check("a5 avail after rd", 32'(data_avail), 32'd0);
    check("a5 flags", 32'({frame_err, parity_err, overrun}), 32'd0);

    for (int i = 0; i < 11; i++) begin
      parity_en  = vecs[i].pen;
      parity_odd = vecs[i].podd;
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
      idle(BIT_CLKS);
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_push));
      if (vecs[i].exp_push) check($sformatf("vec%0d d", i), 32'(d), 32'(vecs[i].data));
      check($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'(vecs[i].exp_perr));
      check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d overrun", i), 32'(overrun), 32'd0);
      if (data_avail) pulse_rd();
      pulse_clr();
      check($sformatf("vec%0d drained", i), 32'(count), 32'd0);
      check($sformatf("vec%0d cleared", i), 32'({frame_err, parity_err}), 32'd0);
    end

    // Fill past capacity.
    parity_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b1);
      idle(16);
      if (i == 4) begin
        check("fill full after 4", 32'(fifo_full), 32'd1);
        check("fill count after 4", 32'(count), 32'd4);
        check("fill no overrun at 4", 32'(overrun), 32'd0);
      end
    end
    check("fill overrun after 5", 32'(overrun), 32'd1);
    check("fill count after 5", 32'(count), 32'd4);
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("fill read %0d", j), 32'(d), 32'(j));
      pulse_rd();
    end
    check("fill empty", 32'(data_avail), 32'd0);
    check("fill overrun sticky", 32'(overrun), 32'd1);
    pulse_clr();
    check("fill overrun cleared", 32'(overrun), 32'd0);

    // Framing error followed by a long low line.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b0);
    check("break frame_err", 32'(frame_err), 32'd1);
    check("break no push", 32'(count), 32'd0);
    idle(BIT_CLKS);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    idle(16);
    check("after break count", 32'(count), 32'd1);
    check("after break d", 32'(d), 32'h3C);
    pulse_rd();
    pulse_clr();

    // Short low glitch is a false start.
    rxd = 1'b0;
    repeat (24) @(negedge clk);
    idle(2 * BIT_CLKS);
    check("glitch count", 32'(count), 32'd0);
    check("glitch flags", 32'({frame_err, parity_err, overrun}), 32'd0);

    // err_clr held across a bad-parity frame: the set must win.
    parity_en = 1'b1; parity_odd = 1'b0;
    err_clr = 1'b1;
    send_head(8'h01);
    drive_bit(1'b0);
    rxd = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (parity_err) begin
        got = 1'b1;
        err_clr = 1'b0;
      end
    end
    err_clr = 1'b0;
    check("setwins parity_err", 32'(got), 32'd1);
    repeat (8) @(negedge clk);
    check("setwins sticky", 32'(parity_err), 32'd1);
    check("setwins count", 32'(count), 32'd0);
    idle(BIT_CLKS);
    pulse_clr();
    check("setwins cleared", 32'(parity_err), 32'd0);

    // Reset in the middle of data bit 3 with two words queued.
    parity_en = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    idle(16);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    idle(16);
    check("pre-reset count", 32'(count), 32'd2);
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    rxd = 1'b1;
    repeat (32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset count", 32'(count), 32'd0);
    check("midreset avail", 32'(data_avail), 32'd0);
    check("midreset full", 32'(fifo_full), 32'd0);
    check("midreset d", 32'(d), 32'd0);
    check("midreset flags", 32'({frame_err, parity_err, overrun}), 32'd0);
    idle(5 * BIT_CLKS + 32);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    idle(16);
    check("post-reset count", 32'(count), 32'd1);
    check("post-reset d", 32'(d), 32'h7E);
    check("post-reset flags", 32'({frame_err, parity_err, overrun}), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
